// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD bypassed read ports, two prioritised
// write-back ports and a pending-write scoreboard. Define REGFILE_DBG_EN for the debug port.
module regfile_mp #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wb0_en,
    input  logic [ADDR_W-1:0]          wb0_addr,
    input  logic [DATA_W-1:0]          wb0_data,
    input  logic                       wb1_en,
    input  logic [ADDR_W-1:0]          wb1_addr,
    input  logic [DATA_W-1:0]          wb1_data,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
`ifdef REGFILE_DBG_EN
    input  logic                       dbg_we,
    input  logic [ADDR_W-1:0]          dbg_addr,
    input  logic [DATA_W-1:0]          dbg_wdata,
    output logic [DATA_W-1:0]          dbg_rdata,
    output logic                       dbg_wack,
`endif
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;

`ifdef REGFILE_DBG_EN
    logic dbg_accept;

    // Debug writes only slip into cycles where neither write-back port is active.
    assign dbg_accept = dbg_we && !wb0_en && !wb1_en && (dbg_addr != '0);
    assign dbg_rdata  = (rst || dbg_addr == '0) ? '0 : mem[dbg_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_wack <= 1'b0;
        end else begin
            dbg_wack <= dbg_accept;
        end
    end
`endif

    // wb0 is written last so it wins a same-address collision with wb1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem <= '{default: '0};
        end else begin
`ifdef REGFILE_DBG_EN
            if (dbg_accept) begin
                mem[dbg_addr] <= dbg_wdata;
            end
`endif
            if (wb1_en && wb1_addr != '0) begin
                mem[wb1_addr] <= wb1_data;
            end
            if (wb0_en && wb0_addr != '0) begin
                mem[wb0_addr] <= wb0_data;
            end
        end
    end

    assign busy_nxt[0] = 1'b0;

    for (genvar a = 1; a < DEPTH; a++) begin : g_sb
        logic iss_hit;
        logic wb_hit;

        assign iss_hit = iss_en && (iss_addr == ADDR_W'(a));
        assign wb_hit  = (wb0_en && wb0_addr == ADDR_W'(a)) ||
                         (wb1_en && wb1_addr == ADDR_W'(a));
        assign busy_nxt[a] = flush   ? 1'b0 :
                             iss_hit ? 1'b1 :
                             wb_hit  ? 1'b0 : busy[a];
    end

    assign cnt_nxt = (ADDR_W+1)'($countones(busy_nxt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit0;
        logic              hit1;

        assign ra   = rd_addr[p*ADDR_W +: ADDR_W];
        assign hit0 = wb0_en && (wb0_addr == ra);
        assign hit1 = wb1_en && (wb1_addr == ra);

        assign rd_data[p*DATA_W +: DATA_W] = (rst || ra == '0) ? '0 :
                                             hit0 ? wb0_data :
                                             hit1 ? wb1_data : mem[ra];
        assign rd_busy[p] = !rst && (ra != '0) && busy[ra] && !(hit0 || hit1);
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Next-generation parametrised integer register file for the core.
- NUM_RD combinational read ports and two prioritised write-back ports (wb0 from EX, wb1 from the LSU/long-latency path), with write-to-read bypass.
- Per-register pending-write scoreboard driving ID-stage stall decisions.
- Optional debug (JTAG) access port.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W; register 0 is hard-wired zero.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data per port.
- rd_busy  out  NUM_RD  per port: source has an outstanding writer and no bypass this cycle.
- wb0_en / wb0_addr / wb0_data  in  1 / ADDR_W / DATA_W  write port 0 (highest priority).
- wb1_en / wb1_addr / wb1_data  in  1 / ADDR_W / DATA_W  write port 1.
- iss_en / iss_addr  in  1 / ADDR_W  issue of an instruction that will write iss_addr.
- flush  in  1  pipeline flush: clear every pending-write bit.
- busy_cnt  out  ADDR_W+1  registered count of set busy bits.
- dbg_we / dbg_addr / dbg_wdata  in  1 / ADDR_W / DATA_W  debug write (REGFILE_DBG_EN only).
- dbg_rdata  out  DATA_W  debug read data (REGFILE_DBG_EN only).
- dbg_wack  out  1  debug write accepted, registered (REGFILE_DBG_EN only).

Behaviour:
- Reset (rst=1, asynchronous): all registers 0; busy bits 0; busy_cnt 0; dbg_wack 0.
- While rst=1: rd_data, rd_busy and dbg_rdata are forced to 0.
- Read port p is purely combinational, 0-cycle latency. Priority:
  - rd_addr==0 -> data 0, busy 0.
  - else wb0_en && wb0_addr==rd_addr -> wb0_data.
  - else wb1_en && wb1_addr==rd_addr -> wb1_data.
  - else mem[rd_addr].
- rd_busy[p] = busy[rd_addr] & ~(wb0 hit | wb1 hit); always 0 for address 0.
- Write on rising edge; writes to address 0 are dropped.
  - wb0 and wb1 to the same address in the same cycle: wb0 value is stored.
  - wb0 and wb1 to different addresses: both are stored.
- Scoreboard next-state per address a != 0, in priority order:
  - flush -> 0.
  - else iss_en && iss_addr==a -> 1 (issue beats a same-cycle write-back to the same address).
  - else (wb0_en && wb0_addr==a) || (wb1_en && wb1_addr==a) -> 0.
  - else hold.
- busy[0] is constant 0.
- Issue to an already busy register is legal (WAW); the bit stays 1 and the first write-back clears it.
- Write-back to a non-busy register is legal: data is written, bit stays 0.
- flush does not block the same-cycle write of register data.
- busy_cnt is the popcount of next-state busy bits, registered: it reflects state after the edge, 1-cycle latency vs inputs.
- Max busy_cnt = 2**ADDR_W-1; no wrap is possible.

Optional Feature:
- Macro: REGFILE_DBG_EN.
- With the macro:
  - dbg_rdata = mem[dbg_addr], combinational, 0 for address 0, no bypass.
  - A debug write takes effect only in cycles with wb0_en=0 and wb1_en=0 and dbg_addr!=0.
  - dbg_wack pulses 1 in the cycle after an accepted write, 0 otherwise.
  - Rejected writes are not queued; the debugger must retry.
  - Debug writes never touch the scoreboard.
- Without the macro: dbg_* ports are absent, no debug write path exists, no extra logic.

Test Plan:
- Reset mid-operation: write x5=0xDEADBEEF, set busy[5], assert rst asynchronously between edges -> rd_data/rd_busy are 0 immediately, busy_cnt=0, then after release x5 reads 0.
- Bypass: wb0 writes x3=0x11, wb1 writes x3=0x22 in the same cycle, rd_addr0=3 -> rd_data0=0x11 that cycle and 0x11 after the edge; the wb1-only variant gives 0x22.
- Zero register: wb0 writes x0=0xFFFFFFFF, iss_en to x0 -> rd_data=0, rd_busy=0, busy_cnt stays 0.
- Scoreboard: issue x7 -> rd_busy=1 next cycle, busy_cnt=1; wb1 x7 with rd_addr1=7 -> rd_busy1=0 that cycle; issue + wb0 to x7 in the same cycle -> busy stays 1; issue x1, x2, then flush -> busy_cnt=0.
- Debug (REGFILE_DBG_EN): dbg_we x9=0xA5A5 alongside wb0_en -> dbg_wack=0, x9 unchanged; retry in an idle cycle -> dbg_wack=1 next cycle, dbg_rdata=0xA5A5.
- Parameter sweep: NUM_RD=4, ADDR_W=4, DATA_W=64 -> all four ports read independent registers correctly, busy_cnt width 5, max count 15.
